// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the Execute stage; stalls the pipeline while busy.
// Optional build macro MULDIV_RADIX4_DIV_EN selects a radix-4 divider (two quotient bits per cycle).
module exec_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2,
   parameter int RD_W       = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_e,
   input  logic            flush_e,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [RD_W-1:0] rd_e,
   output logic            busy_e,
   output logic            done_e,
   output logic [XLEN-1:0] result_e,
   output logic [RD_W-1:0] rd_out
);

`ifdef MULDIV_RADIX4_DIV_EN
   localparam int DIV_ITERS = XLEN / 2;
`else
   localparam int DIV_ITERS = XLEN;
`endif
   localparam int MAX_CNT = (DIV_ITERS > MUL_STAGES) ? DIV_ITERS : MUL_STAGES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]       op_q;
   logic [RD_W-1:0]  rdLatch_q, rdHold_q;
   logic [XLEN-1:0]  opA_q, resultHold_q;
   logic             special_q, divZero_q, negQ_q, negR_q;
   logic [XLEN-1:0]  divRem_q, divQuo_q, divisor_q;
   logic [2*XLEN-1:0] prodPipe_q [MUL_STAGES];

   logic             accept, isDiv, divSigned, aNeg, bNeg, bZero, ovf, special;
   logic [XLEN:0]    extA, extB;
   logic [2*XLEN-1:0] mulProd, step1, stepOut, mulDone;
   logic [XLEN-1:0]  quoFix, remFix, doneResult;

   // One restoring step: shift in the next dividend bit and subtract if it fits.
   function automatic logic [2*XLEN-1:0] divStep(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
      logic [XLEN:0] shifted;
      logic [XLEN:0] diff;
      shifted = {rem, quo[XLEN-1]};
      diff    = shifted - {1'b0, dvs};
      if (!diff[XLEN]) begin
         return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
      end
      return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
   endfunction

   assign accept    = (state_q == ST_IDLE) && start_e && !flush_e;
   assign isDiv     = md_op[2];
   assign divSigned = !md_op[0];
   assign aNeg      = divSigned && src_a[XLEN-1];
   assign bNeg      = divSigned && src_b[XLEN-1];
   assign bZero     = (src_b == '0);
   assign ovf       = divSigned && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
   assign special   = bZero || ovf;

   // Operand extension to XLEN+1 bits chooses signed/unsigned; the wide product is then exact mod 2^(2*XLEN).
   assign extA    = {(md_op[1:0] != 2'b11) && src_a[XLEN-1], src_a};
   assign extB    = {!md_op[1] && src_b[XLEN-1], src_b};
   assign mulProd = {{(XLEN-1){extA[XLEN]}}, extA} * {{(XLEN-1){extB[XLEN]}}, extB};

   always_comb begin
      step1 = divStep(divRem_q, divQuo_q, divisor_q);
`ifdef MULDIV_RADIX4_DIV_EN
      stepOut = divStep(step1[2*XLEN-1:XLEN], step1[XLEN-1:0], divisor_q);
`else
      stepOut = step1;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!isDiv) begin
                  if (MUL_STAGES == 1) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_MUL;
                     cnt_d   = CNT_W'(MUL_STAGES - 2);
                  end
               end else if (special) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DIV;
                  cnt_d   = CNT_W'(DIV_ITERS - 1);
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush_e) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         resultHold_q <= '0;
         rdHold_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (done_e) begin
            resultHold_q <= doneResult;
            rdHold_q     <= rdLatch_q;
         end
      end
   end

   // Datapath registers need no reset: they are always reloaded on accept before being observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q        <= md_op;
         rdLatch_q   <= rd_e;
         opA_q       <= src_a;
         special_q   <= special;
         divZero_q   <= bZero;
         negQ_q      <= aNeg ^ bNeg;
         negR_q      <= aNeg;
         divRem_q    <= '0;
         divQuo_q    <= aNeg ? -src_a : src_a;
         divisor_q   <= bNeg ? -src_b : src_b;
         prodPipe_q[0] <= mulProd;
      end else if (state_q == ST_DIV) begin
         divRem_q <= stepOut[2*XLEN-1:XLEN];
         divQuo_q <= stepOut[XLEN-1:0];
      end
      for (int k = 1; k < MUL_STAGES; k++) begin
         prodPipe_q[k] <= prodPipe_q[k-1];
      end
   end

   assign mulDone = prodPipe_q[MUL_STAGES-1];
   assign quoFix  = negQ_q ? -divQuo_q : divQuo_q;
   assign remFix  = negR_q ? -divRem_q : divRem_q;

   always_comb begin
      doneResult = '0;
      if (!op_q[2]) begin
         doneResult = (op_q[1:0] == 2'b00) ? mulDone[XLEN-1:0] : mulDone[2*XLEN-1:XLEN];
      end else if (special_q) begin
         if (divZero_q) begin
            doneResult = op_q[1] ? opA_q : '1;
         end else begin
            doneResult = op_q[1] ? '0 : opA_q;
         end
      end else begin
         doneResult = op_q[1] ? remFix : quoFix;
      end
   end

   assign busy_e   = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign done_e   = (state_q == ST_DONE) && !flush_e;
   assign result_e = done_e ? doneResult : resultHold_q;
   assign rd_out   = done_e ? rdLatch_q : rdHold_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: directed cases plus randomized ops against an arithmetic reference.
module tb_exec_muldiv_unit;

   localparam int XLEN = 32;
   localparam int MS   = 2;
   localparam int RD_W = 5;
`ifdef MULDIV_RADIX4_DIV_EN
   localparam int DIV_LAT = XLEN/2 + 1;
`else
   localparam int DIV_LAT = XLEN + 1;
`endif
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic            clk = 1'b0;
   logic            reset, start_e, flush_e;
   logic [2:0]      md_op;
   logic [XLEN-1:0] src_a, src_b;
   logic [RD_W-1:0] rd_e;
   logic            busy_e, done_e;
   logic [XLEN-1:0] result_e;
   logic [RD_W-1:0] rd_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] lastResult = '0;
   logic [4:0]  lastRd = '0;

   exec_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .RD_W(RD_W)) dut (
      .clk(clk), .reset(reset), .start_e(start_e), .flush_e(flush_e), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .rd_e(rd_e), .busy_e(busy_e), .done_e(done_e),
      .result_e(result_e), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   // Arithmetic reference model following the RISC-V M-extension rules.
   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa;
      int          sb;
      longint      p;
      logic [63:0] up;
      sa = a;
      sb = b;
      case (op)
         3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
         3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return MS;
      if (b == 0 || (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF)) return 1;
      return DIV_LAT;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      md_op   = op;
      src_a   = a;
      src_b   = b;
      rd_e    = rd;
      start_e = 1'b1;
      flush_e = 1'b0;
   endtask

   // Starts an op in the next cycle (cycle 0) and follows it to done_e, scrambling inputs while busy.
   task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] exp;
      int          lat;
      bit          busyDropped;
      exp = refModel(op, a, b);
      lat = 0;
      busyDropped = 1'b0;
      @(posedge clk); #1;
      applyStimulus(op, a, b, rd);
      @(negedge clk);
      checkOutput({name, " busy@0"}, busy_e, 1);
      checkOutput({name, " noDone@0"}, done_e, 0);
      checkOutput({name, " heldResult"}, result_e, lastResult);
      checkOutput({name, " heldRd"}, rd_out, lastRd);
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            start_e = 1'b0;
            src_a   = $urandom;
            src_b   = $urandom;
            rd_e    = RD_W'($urandom);
            md_op   = 3'($urandom);
         end
         @(negedge clk);
         if (done_e) begin
            lat = c;
            break;
         end
         if (!busy_e) busyDropped = 1'b1;
      end
      checkOutput({name, " latency"}, lat, expLatency(op, a, b));
      checkOutput({name, " busyHeld"}, busyDropped, 0);
      if (lat != 0) begin
         checkOutput({name, " result"}, result_e, exp);
         checkOutput({name, " rd"}, rd_out, rd);
         checkOutput({name, " busyAtDone"}, busy_e, 0);
      end
      lastResult = exp;
      lastRd     = rd;
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit          sawDone;
      reset   = 1'b1;
      start_e = 1'b0;
      flush_e = 1'b0;
      md_op   = '0;
      src_a   = '0;
      src_b   = '0;
      rd_e    = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", busy_e, 0);
      checkOutput("reset done", done_e, 0);
      checkOutput("reset result", result_e, 0);
      checkOutput("reset rd", rd_out, 0);

      runOp("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
      runOp("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      runOp("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      runOp("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      runOp("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd5);
      runOp("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd6);
      runOp("DIV -100/7", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd7);
      runOp("REM -100/7", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd8);
      runOp("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd9);
      runOp("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd10);
      runOp("DIV ovf", 3'd4, MIN_INT, 32'hFFFF_FFFF, 5'd11);
      runOp("REM ovf", 3'd6, MIN_INT, 32'hFFFF_FFFF, 5'd12);

      // Flush an in-flight DIVU at cycle 10, then start a MUL at cycle 12.
      @(posedge clk); #1;
      applyStimulus(3'd5, 32'd1000, 32'd7, 5'd13);
      sawDone = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 1) start_e = 1'b0;
         if (c == 10) flush_e = 1'b1;
         @(negedge clk);
         if (done_e) sawDone = 1'b1;
      end
      checkOutput("flush busy@10", busy_e, 1);
      @(posedge clk); #1 flush_e = 1'b0;
      @(negedge clk);
      checkOutput("flush busy@11", busy_e, 0);
      checkOutput("flush noDone", sawDone | done_e, 0);
      runOp("MUL 3*4 after flush", 3'd0, 32'd3, 32'd4, 5'd14);

      // start_e together with flush_e in IDLE must not be accepted.
      @(posedge clk); #1;
      applyStimulus(3'd0, 32'd5, 32'd6, 5'd15);
      flush_e = 1'b1;
      @(negedge clk);
      checkOutput("start+flush busy", busy_e, 0);
      sawDone = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         start_e = 1'b0;
         flush_e = 1'b0;
         @(negedge clk);
         if (done_e || busy_e) sawDone = 1'b1;
      end
      checkOutput("start+flush ignored", sawDone, 0);
      checkOutput("start+flush result", result_e, lastResult);

      // Reset in cycle 5 of a DIV clears all outputs and kills the op.
      @(posedge clk); #1;
      applyStimulus(3'd4, 32'd1000, 32'd3, 5'd16);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 1) start_e = 1'b0;
         if (c == 5) reset = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("midop reset busy", busy_e, 0);
      checkOutput("midop reset done", done_e, 0);
      checkOutput("midop reset result", result_e, 0);
      checkOutput("midop reset rd", rd_out, 0);
      sawDone = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_e) sawDone = 1'b1;
      end
      checkOutput("midop reset noDone", sawDone, 0);
      lastResult = '0;
      lastRd     = '0;

      // Randomized ops, biased toward the divide special cases.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         runOp("random", rop, ra, rb, 5'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
